y_ctrl: RTL and testbench
=========================

Y_CTRL -- requirements
Module: y_ctrl

Interface
REQ-001 Parameter ENTRY, default 32'd128, PC value loaded on start.
REQ-002 Parameter MAX_INS, default 11, instructions retired before HALT; 0 means unlimited.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 start  input  1  level; begins execution from IDLE.
REQ-006 ins  input  32  instruction word from fetch stage, valid in FETCH.
REQ-007 zero  input  1  ALU zero flag, sampled in EXEC.
REQ-008 PCin  output  32  registered program counter driven to fetch stage.
REQ-009 RegDst, RegWrite, ALUSrc, MemRead, MemWrite  output  1 each  datapath controls.
REQ-010 op  output  3  ALU operation.
REQ-011 state  output  3  current FSM state (debug).
REQ-012 retired  output  8  count of completed instructions.
REQ-013 done  output  1  sticky; set on entering HALT.
REQ-014 err  output  1  sticky; set on illegal opcode.

Function
REQ-015 States IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6; one cycle per state except IDLE/HALT.
REQ-016 IDLE: start=1 -> FETCH, PCin <= ENTRY; else stay.
REQ-017 FETCH: IR <= ins; -> DECODE.
REQ-018 DECODE: opcode IR[31:26]; legal = 0 (R), 2 (j), 4 (beq), 8 (addi), 0x23 (lw), 0x2b (sw); 0x3f -> HALT with done=1; any other -> HALT with done=1, err=1; else -> EXEC.
REQ-019 R-format op from IR[5:0]: 0x20->010, 0x22->110, 0x24->000, 0x25->001, 0x2a->111; other funct -> HALT, err=1.
REQ-020 addi, lw, sw -> op=010; beq -> op=110; j -> op=010, no effect.
REQ-021 RegDst=1 for R only; ALUSrc=1 for addi/lw/sw, 0 otherwise; both plus op held stable from DECODE through last state of the instruction, 0 in IDLE/FETCH/HALT.
REQ-022 EXEC: R/addi -> WB; lw/sw -> MEM; j -> PCin <= {PCin+4 [31:28], IR[25:0], 2'b00}, retire, -> FETCH; beq -> PCin <= zero ? PCin+4+(sext(IR[15:0])<<2) : PCin+4, retire, -> FETCH.
REQ-023 MEM: lw: MemRead=1, -> WB; sw: MemWrite=1, PCin <= PCin+4, retire, -> FETCH.
REQ-024 WB: RegWrite=1 (exactly one cycle), PCin <= PCin+4, retire, -> FETCH.
REQ-025 RegWrite, MemRead, MemWrite are 0 in every state not named above.
REQ-026 PC arithmetic modulo 2^32; 0xFFFFFFFC+4 wraps to 0.
REQ-027 Retire increments retired (saturates at 255); if MAX_INS!=0 and retired+1 == MAX_INS, next state is HALT instead of FETCH, done=1.
REQ-028 HALT: all controls 0, PCin frozen; exits only via reset; start ignored.
REQ-029 Illegal instructions are not retired.

Reset
REQ-030 rst_n=0 asynchronously forces state=IDLE, PCin=0, IR=0, retired=0, done=0, err=0, all controls 0, op=000.
REQ-031 Reset asserted mid-instruction aborts it with no RegWrite/MemWrite pulse; after release FSM waits in IDLE for start.

Verification
REQ-032 start with ins=0x014B4820 (add $9,$10,$11) -> FETCH,DECODE,EXEC,WB; in WB RegWrite=1, RegDst=1, ALUSrc=0, op=010; PCin 128->132; retired=1.
REQ-033 ins=0x1000FFFF (beq, imm=-1) at PCin=132 with zero=1 -> PCin=132 after EXEC; zero=0 -> PCin=136; RegWrite never 1.
REQ-034 ins=0x08000020 (j) at PCin=128 -> PCin=0x00000080 after EXEC, 3 cycles total.
REQ-035 ins=0x8D280004 (lw) -> MemRead=1 in MEM only, RegWrite=1 in WB only, ALUSrc=1, 5 cycles; ins=0xAD280004 (sw) -> MemWrite=1 one cycle, RegWrite=0.
REQ-036 Default MAX_INS, 11 consecutive addi -> done=1, state=HALT, retired=11, PCin=172; ins=0xFC000000 -> HALT, err=0; ins=0x1C000000 -> HALT, err=1.
REQ-037 rst_n pulsed low during WB -> outputs zero immediately without clock, state=IDLE, no RegWrite pulse observed.

Source files
------------

// File: rtl/y_ctrl.sv
// y_ctrl -- multi-cycle control unit for a small MIPS-like core.
//
// Purpose: sequences every instruction through FETCH/DECODE/EXEC/MEM/WB,
// owns the program counter and instruction register, generates the
// datapath control strobes, counts retired instructions and halts on a
// HALT opcode, an illegal instruction or a retire limit.
//
// Ports:
//   clk        single clock, rising edge
//   rst_n      asynchronous active-low reset
//   start      level; leaves IDLE and starts execution at ENTRY
//   ins[31:0]  instruction word from fetch, captured in FETCH
//   zero       ALU zero flag, used by beq in EXEC
//   PCin[31:0] registered program counter
//   RegDst, RegWrite, ALUSrc, MemRead, MemWrite   datapath controls
//   op[2:0]    ALU operation
//   state[2:0] current FSM state (debug)
//   retired    completed-instruction count, saturating at 255
//   done       sticky, set on entering HALT
//   err        sticky, set on an illegal instruction
module y_ctrl #(
  parameter logic [31:0] ENTRY   = 32'd128,
  parameter int          MAX_INS = 11
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] ins,
  input  logic        zero,
  output logic [31:0] PCin,
  output logic        RegDst,
  output logic        RegWrite,
  output logic        ALUSrc,
  output logic        MemRead,
  output logic        MemWrite,
  output logic [2:0]  op,
  output logic [2:0]  state,
  output logic [7:0]  retired,
  output logic        done,
  output logic        err
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_HALT   = 3'd6;

  localparam logic       LIMIT_EN = (MAX_INS != 0);
  localparam logic [8:0] LIMIT    = 9'(MAX_INS);

  logic [2:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [7:0]  retired_q, retired_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  // Instruction decode, driven from the captured IR
  logic [5:0]  opcode, funct;
  logic        is_r, is_j, is_beq, is_addi, is_lw, is_sw;
  logic        r_ok, legal;
  logic [2:0]  r_op, alu_op;

  assign opcode  = ir_q[31:26];
  assign funct   = ir_q[5:0];
  assign is_r    = (opcode == 6'h00);
  assign is_j    = (opcode == 6'h02);
  assign is_beq  = (opcode == 6'h04);
  assign is_addi = (opcode == 6'h08);
  assign is_lw   = (opcode == 6'h23);
  assign is_sw   = (opcode == 6'h2b);

  always_comb begin
    r_ok = 1'b1;
    r_op = 3'b010;
    case (funct)
      6'h20:   r_op = 3'b010;
      6'h22:   r_op = 3'b110;
      6'h24:   r_op = 3'b000;
      6'h25:   r_op = 3'b001;
      6'h2a:   r_op = 3'b111;
      default: r_ok = 1'b0;
    endcase
  end

  assign legal  = (is_r & r_ok) | is_j | is_beq | is_addi | is_lw | is_sw;
  assign alu_op = is_r ? r_op : (is_beq ? 3'b110 : 3'b010);

  // PC candidates
  logic [31:0] pc_plus4, pc_jump, pc_branch;
  assign pc_plus4  = pc_q + 32'd4;
  assign pc_jump   = {pc_plus4[31:28], ir_q[25:0], 2'b00};
  assign pc_branch = pc_plus4 + {{14{ir_q[15]}}, ir_q[15:0], 2'b00};

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      pc_q      <= 32'd0;
      ir_q      <= 32'd0;
      retired_q <= 8'd0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      retired_q <= retired_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  // Next-state logic
  logic retire;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    retired_d = retired_q;
    done_d    = done_q;
    err_d     = err_q;
    retire    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FETCH;
          pc_d    = ENTRY;
        end
      end
      S_FETCH: begin
        ir_d    = ins;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        if (legal) begin
          state_d = S_EXEC;
        end else begin
          // 0x3f is a clean halt; anything else unknown is an error halt
          state_d = S_HALT;
          done_d  = 1'b1;
          err_d   = (opcode != 6'h3f);
        end
      end
      S_EXEC: begin
        if (is_r || is_addi) begin
          state_d = S_WB;
        end else if (is_lw || is_sw) begin
          state_d = S_MEM;
        end else if (is_j) begin
          pc_d   = pc_jump;
          retire = 1'b1;
        end else begin
          pc_d   = zero ? pc_branch : pc_plus4;
          retire = 1'b1;
        end
      end
      S_MEM: begin
        if (is_lw) begin
          state_d = S_WB;
        end else begin
          pc_d   = pc_plus4;
          retire = 1'b1;
        end
      end
      S_WB: begin
        pc_d   = pc_plus4;
        retire = 1'b1;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Retirement: count, then either fetch the next instruction or stop at
    // the limit. The limit compares the pre-increment count plus one so a
    // saturated counter can never alias onto it.
    if (retire) begin
      retired_d = (retired_q == 8'hFF) ? 8'hFF : retired_q + 8'd1;
      if (LIMIT_EN && (({1'b0, retired_q} + 9'd1) == LIMIT)) begin
        state_d = S_HALT;
        done_d  = 1'b1;
      end else begin
        state_d = S_FETCH;
      end
    end
  end

  // Output logic: controls come straight from state and IR so an
  // asynchronous reset clears them without waiting for a clock edge.
  logic in_instr;
  assign in_instr = (state_q == S_DECODE) || (state_q == S_EXEC) ||
                    (state_q == S_MEM)    || (state_q == S_WB);

  always_comb begin
    RegDst   = 1'b0;
    ALUSrc   = 1'b0;
    op       = 3'b000;
    RegWrite = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    if (in_instr && legal) begin
      RegDst   = is_r;
      ALUSrc   = is_addi | is_lw | is_sw;
      op       = alu_op;
      RegWrite = (state_q == S_WB);
      MemRead  = (state_q == S_MEM) & is_lw;
      MemWrite = (state_q == S_MEM) & is_sw;
    end
  end

  assign PCin    = pc_q;
  assign state   = state_q;
  assign retired = retired_q;
  assign done    = done_q;
  assign err     = err_q;

endmodule

// File: tb/tb_y_ctrl.sv
// tb_y_ctrl -- self-checking bench for y_ctrl.
// An instruction-level reference model turns each issued instruction into
// the list of per-cycle outputs it must produce; a compare process checks
// every cycle against that list. Directed cases pin the model with
// hand-computed values, then randomized programs exercise it broadly.
module tb_y_ctrl;

  localparam logic [31:0] ENTRY   = 32'd128;
  localparam int          MAX_INS = 11;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_HALT   = 3'd6;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] ins = 32'd0;
  logic        zero = 1'b0;
  logic [31:0] PCin;
  logic        RegDst, RegWrite, ALUSrc, MemRead, MemWrite;
  logic [2:0]  op;
  logic [2:0]  state;
  logic [7:0]  retired;
  logic        done, err;

  y_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ins(ins), .zero(zero),
    .PCin(PCin), .RegDst(RegDst), .RegWrite(RegWrite), .ALUSrc(ALUSrc),
    .MemRead(MemRead), .MemWrite(MemWrite), .op(op), .state(state),
    .retired(retired), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Expected per-cycle output vectors, oldest first
  logic [52:0] exp_q[$];

  // Architectural model state
  logic [31:0] m_pc;
  logic [7:0]  m_ret;
  logic        m_done, m_err, m_halted;

  function automatic logic [52:0] mk(input logic [2:0] st, input logic [31:0] pc,
                                     input logic rd, input logic rw, input logic as,
                                     input logic mr, input logic mw, input logic [2:0] o,
                                     input logic [7:0] r, input logic d, input logic e);
    return {st, pc, rd, rw, as, mr, mw, o, r, d, e};
  endfunction

  function automatic logic [52:0] dut_vec();
    return {state, PCin, RegDst, RegWrite, ALUSrc, MemRead, MemWrite, op, retired, done, err};
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, got, expv);
    end
  endtask

  // Compare process: every tracked cycle is checked mid-cycle
  always @(negedge clk) begin
    logic [52:0] e;
    if (rst_n && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check($sformatf("cycle@%0t", $time), dut_vec(), e);
    end
  end

  // Instruction-level model: pushes the cycles of one instruction, starting
  // with its FETCH cycle, and updates PC / count / flags.
  task automatic model_instr(input logic [31:0] i, input logic z, output int n);
    logic [5:0]  opc, fn;
    logic        is_r, is_j, is_beq, is_addi, is_lw, is_sw, r_ok, legal, rd, as;
    logic [2:0]  aop;
    logic [31:0] p4, npc;
    int          off;
    opc = i[31:26];
    fn  = i[5:0];
    is_r = (opc == 6'h00); is_j = (opc == 6'h02); is_beq = (opc == 6'h04);
    is_addi = (opc == 6'h08); is_lw = (opc == 6'h23); is_sw = (opc == 6'h2b);
    r_ok = 1'b1;
    aop  = 3'b010;
    if (is_r) begin
      case (fn)
        6'h20: aop = 3'b010;
        6'h22: aop = 3'b110;
        6'h24: aop = 3'b000;
        6'h25: aop = 3'b001;
        6'h2a: aop = 3'b111;
        default: r_ok = 1'b0;
      endcase
    end else if (is_beq) begin
      aop = 3'b110;
    end
    legal = (is_r && r_ok) || is_j || is_beq || is_addi || is_lw || is_sw;

    exp_q.push_back(mk(S_FETCH, m_pc, 0, 0, 0, 0, 0, 3'b000, m_ret, m_done, m_err));
    if (!legal) begin
      exp_q.push_back(mk(S_DECODE, m_pc, 0, 0, 0, 0, 0, 3'b000, m_ret, m_done, m_err));
      m_done   = 1'b1;
      m_err    = (opc != 6'h3f);
      m_halted = 1'b1;
      n = 2;
      return;
    end
    rd = is_r;
    as = is_addi || is_lw || is_sw;
    exp_q.push_back(mk(S_DECODE, m_pc, rd, 0, as, 0, 0, aop, m_ret, m_done, m_err));
    exp_q.push_back(mk(S_EXEC,   m_pc, rd, 0, as, 0, 0, aop, m_ret, m_done, m_err));
    n = 3;
    if (is_lw) begin
      exp_q.push_back(mk(S_MEM, m_pc, rd, 0, as, 1, 0, aop, m_ret, m_done, m_err));
      exp_q.push_back(mk(S_WB,  m_pc, rd, 1, as, 0, 0, aop, m_ret, m_done, m_err));
      n = 5;
    end else if (is_sw) begin
      exp_q.push_back(mk(S_MEM, m_pc, rd, 0, as, 0, 1, aop, m_ret, m_done, m_err));
      n = 4;
    end else if (is_r || is_addi) begin
      exp_q.push_back(mk(S_WB,  m_pc, rd, 1, as, 0, 0, aop, m_ret, m_done, m_err));
      n = 4;
    end

    p4 = m_pc + 32'd4;
    if (is_j) begin
      npc = {p4[31:28], i[25:0], 2'b00};
    end else if (is_beq && z) begin
      off = int'($signed(i[15:0]));
      npc = p4 + 32'(off * 4);
    end else begin
      npc = p4;
    end
    if (MAX_INS != 0 && int'(m_ret) + 1 == MAX_INS) begin
      m_done   = 1'b1;
      m_halted = 1'b1;
    end
    m_pc  = npc;
    m_ret = (m_ret == 8'd255) ? 8'd255 : m_ret + 8'd1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    start = 1'b0;
    #1;
    check("reset_outputs", dut_vec(), 64'd0);
    exp_q.delete();
    tick();
    rst_n    = 1'b1;
    m_pc     = 32'd0;
    m_ret    = 8'd0;
    m_done   = 1'b0;
    m_err    = 1'b0;
    m_halted = 1'b0;
  endtask

  task automatic idle(input int k);
    repeat (k) begin
      exp_q.push_back(mk(S_IDLE, m_pc, 0, 0, 0, 0, 0, 3'b000, m_ret, m_done, m_err));
      tick();
    end
  endtask

  task automatic begin_run();
    start = 1'b1;
    exp_q.push_back(mk(S_IDLE, m_pc, 0, 0, 0, 0, 0, 3'b000, m_ret, m_done, m_err));
    tick();
    m_pc = ENTRY;
  endtask

  task automatic halt_cycles(input int k);
    repeat (k) begin
      start = 1'($urandom_range(0, 1));
      exp_q.push_back(mk(S_HALT, m_pc, 0, 0, 0, 0, 0, 3'b000, m_ret, m_done, m_err));
      tick();
    end
  endtask

  task automatic do_instr(input logic [31:0] i, input logic z);
    int n;
    ins   = i;
    zero  = z;
    start = 1'($urandom_range(0, 1));
    model_instr(i, z, n);
    tick();
    ins = $urandom();   // IR must hold the word captured in FETCH
    repeat (n - 1) tick();
  endtask

  function automatic logic [31:0] rand_ins();
    int          r;
    logic [31:0] w;
    logic [5:0]  fl [5];
    fl[0] = 6'h20; fl[1] = 6'h22; fl[2] = 6'h24; fl[3] = 6'h25; fl[4] = 6'h2a;
    r = $urandom_range(0, 99);
    w = $urandom();
    if (r < 20)      w = {6'h00, w[25:6], fl[$urandom_range(0, 4)]};
    else if (r < 30) w = {6'h08, w[25:0]};
    else if (r < 42) w = {6'h23, w[25:0]};
    else if (r < 54) w = {6'h2b, w[25:0]};
    else if (r < 72) w = {6'h04, w[25:0]};
    else if (r < 84) w = {6'h02, w[25:0]};
    else if (r < 90) w = {6'h00, w[25:0]};
    else if (r < 94) w = {6'h3f, w[25:0]};
    return w;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int cnt;
    tick();

    // add, beq taken/not taken, lw, sw from ENTRY
    do_reset();
    idle(3);
    begin_run();
    check("start_pc", PCin, 32'd128);
    do_instr(32'h014B4820, 1'b0);
    check("add_pc", PCin, 32'd132);
    check("add_retired", retired, 8'd1);
    check("add_state", state, S_FETCH);
    do_instr(32'h1000FFFF, 1'b1);
    check("beq_taken_pc", PCin, 32'd132);
    do_instr(32'h1000FFFF, 1'b0);
    check("beq_not_taken_pc", PCin, 32'd136);
    do_instr(32'h8D280004, 1'b0);
    check("lw_pc", PCin, 32'd140);
    do_instr(32'hAD280004, 1'b0);
    check("sw_pc", PCin, 32'd144);
    check("sw_retired", retired, 8'd5);

    // jump, backward branch below zero, wrap forward through zero
    do_reset();
    idle(1);
    begin_run();
    do_instr(32'h08000020, 1'b0);
    check("j_pc", PCin, 32'h0000_0080);
    check("j_state", state, S_FETCH);
    do_instr(32'h1000FFDE, 1'b1);
    check("beq_wrap_pc", PCin, 32'hFFFF_FFFC);
    do_instr(32'h21290001, 1'b0);
    check("pc_wrap_zero", PCin, 32'h0000_0000);

    // retire limit
    do_reset();
    idle(1);
    begin_run();
    repeat (11) do_instr(32'h21290001, 1'b0);
    check("limit_state", state, S_HALT);
    check("limit_done", done, 1'b1);
    check("limit_retired", retired, 8'd11);
    check("limit_pc", PCin, 32'd172);
    halt_cycles(4);

    // HALT opcode
    do_reset();
    idle(1);
    begin_run();
    do_instr(32'hFC000000, 1'b0);
    check("halt_op_state", state, S_HALT);
    check("halt_op_err", err, 1'b0);
    check("halt_op_done", done, 1'b1);
    halt_cycles(2);

    // illegal opcode after one good instruction
    do_reset();
    idle(1);
    begin_run();
    do_instr(32'h014B4820, 1'b0);
    do_instr(32'h1C000000, 1'b0);
    check("illegal_err", err, 1'b1);
    check("illegal_not_retired", retired, 8'd1);
    halt_cycles(2);

    // illegal R funct
    do_reset();
    idle(1);
    begin_run();
    do_instr(32'h014B4821, 1'b0);
    check("bad_funct_err", err, 1'b1);
    check("bad_funct_state", state, S_HALT);
    halt_cycles(2);

    // reset during WB
    do_reset();
    idle(1);
    begin_run();
    ins  = 32'h014B4820;
    zero = 1'b0;
    tick();
    ins = $urandom();
    tick();
    tick();
    check("pre_reset_wb_state", state, S_WB);
    check("pre_reset_wb_regwrite", RegWrite, 1'b1);
    do_reset();
    check("post_reset_regwrite", RegWrite, 1'b0);
    idle(3);
    begin_run();
    do_instr(32'hAD280004, 1'b0);
    check("recover_pc", PCin, 32'd132);

    // randomized programs
    for (int run = 0; run < 25; run++) begin
      do_reset();
      idle($urandom_range(0, 2));
      begin_run();
      cnt = 0;
      while (!m_halted && cnt < 14) begin
        do_instr(rand_ins(), 1'($urandom_range(0, 1)));
        cnt++;
      end
      if (m_halted) halt_cycles(3);
    end

    tick();
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
